// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - datapath/ALU bus shared by the multiply sequencer and its surroundings
// slave is the sequencer; master is the datapath plus ALU side.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [2:0]       dp_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [1:0]       nz;

    modport master (
        output start, op_a, op_b, dp_a, dp_b, dp_ctrl, alu_result,
        input  alu_a, alu_b, alu_ctrl, stall, done, product, nz
    );

    modport slave (
        input  start, op_a, op_b, dp_a, dp_b, dp_ctrl, alu_result,
        output alu_a, alu_b, alu_ctrl, stall, done, product, nz
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiply sequenced on the shared 32-bit ALU
// Owns the ALU input mux: passthrough when not running, ADD of acc + partial product while running.
module alu_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic                clk,
    input logic                reset,
    alu_mul_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] product;
    logic [1:0]       nz;
    logic             skip_run;
    logic             last_iter;
    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_b_c;
    logic [2:0]       alu_ctrl_c;
    logic             stall_c;
    logic             done_c;

    // last_iter looks at the multiplier as it will be after this cycle's shift
    assign skip_run  = EARLY_EXIT && (bus.op_b == '0);
    assign last_iter = (cnt == LAST_CNT) || (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        alu_a_c    = bus.dp_a;
        alu_b_c    = bus.dp_b;
        alu_ctrl_c = bus.dp_ctrl;
        stall_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stall_c    = 1'b1;
                    state_next = skip_run ? DONE : RUN;
                end
            end
            RUN: begin
                stall_c    = 1'b1;
                alu_a_c    = acc;
                alu_b_c    = mplier[0] ? mcand : '0;
                alu_ctrl_c = 3'b000;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            stall_c = 1'b0;
            done_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
            nz      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        cnt    <= '0;
                        if (skip_run) begin
                            product <= '0;
                            nz      <= 2'b01;
                        end
                    end
                end
                RUN: begin
                    acc    <= bus.alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (last_iter) begin
                        product <= bus.alu_result;
                        nz      <= {bus.alu_result[WIDTH-1], bus.alu_result == '0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a    = alu_a_c;
    assign bus.alu_b    = alu_b_c;
    assign bus.alu_ctrl = alu_ctrl_c;
    assign bus.stall    = stall_c;
    assign bus.done     = done_c;
    assign bus.product  = product;
    assign bus.nz       = nz;
endmodule
